// File: rtl/carrier_pkg.sv
// carrier_pkg: state encoding and carrier constants shared with the triangle carrier generator.
package carrier_pkg;
   localparam int CARRIER_W = 16;
   localparam logic [CARRIER_W-1:0] DEF_PERIOD = 16'd22222;
   localparam logic [CARRIER_W-1:0] MIN_PERIOD = 16'd100;
   typedef enum logic [2:0] {IDLE, ARMED, APPLY, SYNC, GAP_WAIT} state_e;
endpackage

// File: rtl/carrier_valley_det.sv
// carrier_valley_det: single-cycle pulse on the first cycle of each run of carrier_angle == 0.
module carrier_valley_det
   import carrier_pkg::*;
(
   input  logic                 clk_20M,
   input  logic                 reset,
   input  logic [CARRIER_W-1:0] angle_i,
   output logic                 valley_o
);
   logic zero, zero_q;
   assign zero = angle_i == '0;
   always_ff @(posedge clk_20M or posedge reset)
      if (reset) zero_q <= 1'b0;
      else zero_q <= zero;
   assign valley_o = zero & ~zero_q;
endmodule

// File: rtl/carrier_sync_ctrl.sv
// carrier_sync_ctrl: stages carrier period/phase writes, applies them at a valley and pulses syn.
// Optional CSC_VALLEY_TIMEOUT_EN: ARMED gives up waiting after 2*frequency+16 cycles.
module carrier_sync_ctrl
   import carrier_pkg::*;
#(
   parameter int unsigned SYN_WIDTH  = 2,
   parameter int unsigned GAP        = 4,
   parameter logic [15:0] RESYNC_CNT = 16'd0
) (
   input  logic        clk_20M,
   input  logic        reset,
   input  logic        cfg_valid,
   output logic        cfg_ready,
   input  logic [15:0] cfg_period,
   input  logic [15:0] cfg_phase,
   output logic        cfg_err,
   input  logic        force_sync,
   input  logic [15:0] carrier_angle,
   output logic [15:0] frequency,
   output logic [15:0] angle_initial,
   output logic        syn,
   output logic        busy,
   output logic        applied,
   output logic        timeout
);
   localparam logic [3:0] SYN_LAST = 4'(SYN_WIDTH - 1);
   localparam logic [3:0] GAP_LAST = 4'(GAP - 1);
   state_e      state_q, state_d;
   logic [15:0] freq_q, freq_d, ang_q, ang_d, shp_q, shp_d, shph_q, shph_d, vcnt_q, vcnt_d;
   logic [3:0]  cnt_q, cnt_d;
   logic        pcfg_q, pcfg_d, psync_q, psync_d, entry_q, entry_d;
   logic        err_q, err_d, app_q, app_d;
   logic        valley, valley_ok, xfer, legal, tmo_hit;

   carrier_valley_det u_valley (
      .clk_20M (clk_20M),
      .reset   (reset),
      .angle_i (carrier_angle),
      .valley_o(valley)
   );

   assign xfer      = cfg_valid && state_q == IDLE;
   assign legal     = cfg_period >= MIN_PERIOD && cfg_phase <= cfg_period;
   // a valley seen in the very cycle ARMED is entered belongs to the old config window
   assign valley_ok = valley & ~entry_q;

   always_comb begin
      state_d = state_q;
      freq_d  = freq_q;
      ang_d   = ang_q;
      shp_d   = shp_q;
      shph_d  = shph_q;
      pcfg_d  = pcfg_q;
      psync_d = psync_q;
      vcnt_d  = state_q == IDLE ? vcnt_q : '0;
      cnt_d   = '0;
      err_d   = 1'b0;
      app_d   = 1'b0;
      case (state_q)
         IDLE: begin
            err_d = xfer & ~legal;
            if (xfer && legal) begin
               shp_d  = cfg_period;
               shph_d = cfg_phase;
               pcfg_d = 1'b1;
            end
            if ((xfer && legal) || force_sync) begin
               psync_d = psync_q | force_sync;
               state_d = ARMED;
            end else if (valley && RESYNC_CNT != '0) begin
               vcnt_d  = vcnt_q + 16'd1 == RESYNC_CNT ? '0 : (&vcnt_q ? vcnt_q : vcnt_q + 16'd1);
               psync_d = psync_q | (vcnt_q + 16'd1 == RESYNC_CNT);
               state_d = vcnt_q + 16'd1 == RESYNC_CNT ? APPLY : IDLE;
            end
         end
         ARMED: begin
            psync_d = psync_q | force_sync;
            if (valley_ok || tmo_hit) begin
               state_d = APPLY;
               freq_d  = pcfg_q ? shp_q : freq_q;
               ang_d   = pcfg_q ? shph_q : ang_q;
               app_d   = pcfg_q;
            end
         end
         APPLY: begin
            pcfg_d  = 1'b0;
            psync_d = 1'b0;
            state_d = SYNC;
         end
         SYNC: begin
            cnt_d   = cnt_q == SYN_LAST ? '0 : cnt_q + 4'd1;
            state_d = cnt_q == SYN_LAST ? GAP_WAIT : SYNC;
         end
         GAP_WAIT: begin
            cnt_d   = cnt_q == GAP_LAST ? '0 : cnt_q + 4'd1;
            state_d = cnt_q == GAP_LAST ? IDLE : GAP_WAIT;
         end
         default: state_d = IDLE;
      endcase
      entry_d = state_d == ARMED && state_q != ARMED;
   end

   always_ff @(posedge clk_20M or posedge reset)
      if (reset) begin
         state_q <= IDLE;
         freq_q  <= DEF_PERIOD;
         ang_q   <= '0;
         shp_q   <= '0;
         shph_q  <= '0;
         vcnt_q  <= '0;
         cnt_q   <= '0;
         pcfg_q  <= 1'b0;
         psync_q <= 1'b0;
         entry_q <= 1'b0;
         err_q   <= 1'b0;
         app_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         freq_q  <= freq_d;
         ang_q   <= ang_d;
         shp_q   <= shp_d;
         shph_q  <= shph_d;
         vcnt_q  <= vcnt_d;
         cnt_q   <= cnt_d;
         pcfg_q  <= pcfg_d;
         psync_q <= psync_d;
         entry_q <= entry_d;
         err_q   <= err_d;
         app_q   <= app_d;
      end

`ifdef CSC_VALLEY_TIMEOUT_EN
   logic [16:0] tcnt_q;
   logic [17:0] tlim;
   logic        tmo_q;
   assign tlim    = {1'b0, freq_q, 1'b0} + 18'd16;
   assign tmo_hit = state_q == ARMED && {1'b0, tcnt_q} + 18'd1 == tlim;
   always_ff @(posedge clk_20M or posedge reset)
      if (reset) begin
         tcnt_q <= '0;
         tmo_q  <= 1'b0;
      end else begin
         tcnt_q <= state_q == ARMED ? (&tcnt_q ? tcnt_q : tcnt_q + 17'd1) : '0;
         tmo_q  <= tmo_hit & ~valley_ok;
      end
   assign timeout = tmo_q;
`else
   assign tmo_hit = 1'b0;
   assign timeout = 1'b0;
`endif

   assign cfg_ready     = state_q == IDLE;
   assign busy          = state_q != IDLE;
   assign syn           = state_q == SYNC;
   assign cfg_err       = err_q;
   assign applied       = app_q;
   assign frequency     = freq_q;
   assign angle_initial = ang_q;
endmodule

// File: tb/tb_carrier_sync_ctrl.sv
// tb_carrier_sync_ctrl: directed stimulus, event-schedule reference model and literal checks.
module tb_carrier_sync_ctrl;
   localparam int RS = 3;
   localparam int SW = 2;
   localparam int GP = 4;
`ifdef CSC_VALLEY_TIMEOUT_EN
   localparam bit TMO = 1'b1;
`else
   localparam bit TMO = 1'b0;
`endif
   logic        clk_20M = 1'b0, reset = 1'b1, cfg_valid = 1'b0, force_sync = 1'b0;
   logic [15:0] cfg_period = '0, cfg_phase = '0, carrier_angle = 16'd7;
   logic        cfg_ready, cfg_err, syn, busy, applied, timeout;
   logic [15:0] frequency, angle_initial;
   int passed = 0, total = 0;

   carrier_sync_ctrl #(.SYN_WIDTH(SW), .GAP(GP), .RESYNC_CNT(16'(RS))) dut (
      .clk_20M(clk_20M), .reset(reset), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
      .cfg_period(cfg_period), .cfg_phase(cfg_phase), .cfg_err(cfg_err),
      .force_sync(force_sync), .carrier_angle(carrier_angle), .frequency(frequency),
      .angle_initial(angle_initial), .syn(syn), .busy(busy), .applied(applied),
      .timeout(timeout)
   );

   always #25 clk_20M = ~clk_20M;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act === exp) passed++;
      else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
   endtask

   // model: mode 0 idle, 1 waiting for valley (age = cycles since entry), 2 post-valley schedule
   int m_freq, m_ang, m_mode, m_age, m_seq, m_shp, m_shph, m_vcnt;
   bit m_pcfg, m_psync, m_app, m_err, m_tmo, m_pz, vly, acc, hit_v, hit_t;

   always @(negedge clk_20M) begin
      if (reset) begin
         m_freq = 22222; m_ang = 0; m_mode = 0; m_age = 0; m_seq = 0; m_shp = 0; m_shph = 0;
         m_vcnt = 0; m_pcfg = 0; m_psync = 0; m_app = 0; m_err = 0; m_tmo = 0; m_pz = 0;
      end
      check("frequency", 32'(frequency), 32'(m_freq));
      check("angle_initial", 32'(angle_initial), 32'(m_ang));
      check("syn", 32'(syn), 32'(m_mode == 2 && m_seq >= 1 && m_seq <= SW));
      check("busy", 32'(busy), 32'(m_mode != 0));
      check("cfg_ready", 32'(cfg_ready), 32'(m_mode == 0));
      check("applied", 32'(applied), 32'(m_app));
      check("cfg_err", 32'(cfg_err), 32'(m_err));
      check("timeout", 32'(timeout), 32'(m_tmo));
      if (!reset) begin
         vly = carrier_angle == 0 && !m_pz;
         m_pz = carrier_angle == 0;
         m_app = 0; m_err = 0; m_tmo = 0;
         if (m_mode == 0) begin
            acc = cfg_valid && cfg_period >= 100 && cfg_phase <= cfg_period;
            if (cfg_valid && !acc) m_err = 1;
            if (acc) begin m_shp = cfg_period; m_shph = cfg_phase; m_pcfg = 1; end
            if (acc || force_sync) begin
               m_psync = m_psync | force_sync; m_mode = 1; m_age = 0; m_vcnt = 0;
            end else if (vly && RS != 0) begin
               m_vcnt++;
               if (m_vcnt == RS) begin m_vcnt = 0; m_psync = 1; m_mode = 2; m_seq = 0; end
            end
         end else if (m_mode == 1) begin
            if (force_sync) m_psync = 1;
            hit_v = vly && m_age > 0;
            hit_t = TMO && m_age + 1 == 2 * m_freq + 16;
            if (hit_v || hit_t) begin
               m_tmo = !hit_v;
               if (m_pcfg) begin m_freq = m_shp; m_ang = m_shph; m_app = 1; end
               m_pcfg = 0; m_psync = 0; m_mode = 2; m_seq = 0;
            end else m_age++;
         end else begin
            m_seq++;
            if (m_seq == 1 + SW + GP) begin m_mode = 0; m_vcnt = 0; end
         end
      end
   end

   task automatic tick(input int n);
      repeat (n) @(posedge clk_20M);
      #1;
   endtask

   task automatic wait_idle();
      for (int i = 0; i < 50 && !cfg_ready; i++) tick(1);
      check("return_to_idle", 32'(cfg_ready), 32'd1);
   endtask

   task automatic write(input logic [15:0] p, input logic [15:0] ph);
      cfg_valid = 1'b1; cfg_period = p; cfg_phase = ph;
      tick(1);
      cfg_valid = 1'b0;
   endtask

   int apps, rises, ph;
   logic ps;

   initial begin
      tick(3);
      check("rst_frequency", 32'(frequency), 32'd22222);
      check("rst_syn", 32'(syn), 32'd0);
      check("rst_ready", 32'(cfg_ready), 32'd1);
      reset = 1'b0;
      tick(1000);
      check("idle_frequency", 32'(frequency), 32'd22222);
      check("idle_angle", 32'(angle_initial), 32'd0);
      check("idle_syn", 32'(syn), 32'd0);
      // legal write mid-ramp, applied only after a valley
      carrier_angle = 16'd123;
      write(16'd500, 16'd250);
      check("armed_busy", 32'(busy), 32'd1);
      tick(10);
      check("held_frequency", 32'(frequency), 32'd22222);
      carrier_angle = 16'd0;
      tick(1);
      carrier_angle = 16'd1;
      check("applied_pulse", 32'(applied), 32'd1);
      check("new_frequency", 32'(frequency), 32'd500);
      check("new_angle", 32'(angle_initial), 32'd250);
      check("syn_before", 32'(syn), 32'd0);
      tick(1); check("syn_c1", 32'(syn), 32'd1);
      tick(1); check("syn_c2", 32'(syn), 32'd1);
      tick(1); check("syn_c3", 32'(syn), 32'd0);
      wait_idle();
      // illegal writes
      write(16'd50, 16'd0);
      check("err_short_period", 32'(cfg_err), 32'd1);
      check("err1_idle", 32'(busy), 32'd0);
      tick(1); check("err1_cleared", 32'(cfg_err), 32'd0);
      write(16'd500, 16'd600);
      check("err_phase_gt_period", 32'(cfg_err), 32'd1);
      check("err2_idle", 32'(busy), 32'd0);
      tick(1);
      check("err_freq_kept", 32'(frequency), 32'd500);
      // merged write+force; zero in the ARMED entry cycle is ignored
      carrier_angle = 16'd5;
      force_sync = 1'b1;
      write(16'd1000, 16'd10);
      force_sync = 1'b0;
      carrier_angle = 16'd0;
      tick(1);
      carrier_angle = 16'd3;
      check("entry_valley_ignored", 32'(busy & ~applied), 32'd1);
      tick(5);
      force_sync = 1'b1;
      tick(1);
      force_sync = 1'b0;
      carrier_angle = 16'd0;
      tick(1);
      carrier_angle = 16'd3;
      apps = 0; rises = 0; ps = 1'b0;
      for (int i = 0; i < 40; i++) begin
         if (applied) apps++;
         if (syn && !ps) rises++;
         ps = syn;
         tick(1);
      end
      check("merged_applied", 32'(apps), 32'd1);
      check("merged_syn", 32'(rises), 32'd1);
      check("merged_frequency", 32'(frequency), 32'd1000);
      // periodic resync every 3rd valley, force_sync during SYNC dropped
      rises = 0; ps = 1'b0;
      for (int i = 0; i < 2500; i++) begin
         ph = i % 400;
         carrier_angle = 16'(ph <= 200 ? ph : 400 - ph);
         if (syn && !ps) begin
            rises++;
            force_sync = rises == 1;
         end else force_sync = 1'b0;
         ps = syn;
         tick(1);
      end
      force_sync = 1'b0;
      carrier_angle = 16'd7;
      check("resync_count", 32'(rises), 32'd2);
      check("resync_idle", 32'(cfg_ready), 32'd1);
      // boundary write period == MIN_PERIOD, phase == period
      write(16'd100, 16'd100);
      check("boundary_accepted", 32'(busy), 32'd1);
      tick(2);
      carrier_angle = 16'd0;
      tick(1);
      carrier_angle = 16'd7;
      check("boundary_frequency", 32'(frequency), 32'd100);
      check("boundary_angle", 32'(angle_initial), 32'd100);
      wait_idle();
      force_sync = 1'b1;
      tick(1);
      force_sync = 1'b0;
`ifdef CSC_VALLEY_TIMEOUT_EN
      tick(215);
      check("timeout_early", 32'(timeout), 32'd0);
      tick(1);
      check("timeout_pulse", 32'(timeout), 32'd1);
      tick(1);
      check("timeout_one_cycle", 32'(timeout), 32'd0);
`else
      tick(300);
      check("wait_forever_busy", 32'(busy), 32'd1);
      check("timeout_tied", 32'(timeout), 32'd0);
      carrier_angle = 16'd0;
      tick(1);
      carrier_angle = 16'd7;
`endif
      wait_idle();
      // reset in the middle of a sync pulse
      write(16'd300, 16'd5);
      tick(2);
      carrier_angle = 16'd0;
      tick(1);
      carrier_angle = 16'd7;
      check("pre_reset_frequency", 32'(frequency), 32'd300);
      tick(1);
      check("pre_reset_syn", 32'(syn), 32'd1);
      #2 reset = 1'b1;
      #1;
      check("async_syn_drop", 32'(syn), 32'd0);
      check("async_frequency", 32'(frequency), 32'd22222);
      tick(1);
      reset = 1'b0;
      tick(5);
      check("post_reset_ready", 32'(cfg_ready), 32'd1);
      check("post_reset_angle", 32'(angle_initial), 32'd0);
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule
